idli_mem_arb_m: RTL and testbench

- Arbiter and sequencer in front of the SQI memory interface.
- Shares the single serial memory path between two requesters:
  - instruction-fetch redirects (branches);
  - load/store requests from the LSU.
- Drives the interface's redirect, write-enable and stall controls, and serialises addresses and store data onto the 4b slice bus.
- Returns fetch to the correct PC after every data access.

---
 rtl/idli_mem_arb_m.sv | 156 +++++++++++++++
 tb/tb_idli_mem_arb_m.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idli_mem_arb_m.sv
// Arbiter/sequencer sharing the SQI memory path between branch redirects and LSU accesses.
// state    | meaning
// FETCH    | instruction stream flowing; requests sampled at boundaries
// BR_ADDR  | branch target shifted out on the slice bus
// LS_ADDR  | data address shifted out
// RET_ADDR | resume fetch address shifted out
// SETUP_F  | waiting for the first instruction word after a redirect
// SETUP_LS | waiting for load data or write-data acceptance
// ST_DATA  | store data period followed by a zero period
module idli_mem_arb_m #(
    parameter bit LS_PRIO = 1'b1
) (
    input  logic        i_sqi_gck,
    input  logic        i_sqi_rst_n,
    input  logic [1:0]  i_sqi_ctr,
    input  logic        i_br_vld,
    input  logic [15:0] i_br_addr,
    output logic        o_br_acp,
    input  logic        i_ls_vld,
    input  logic        i_ls_wr,
    input  logic [15:0] i_ls_addr,
    input  logic [15:0] i_ls_wdata,
    input  logic [15:0] i_ls_pc,
    output logic        o_ls_acp,
    output logic        o_ls_done,
    output logic [15:0] o_ls_rdata,
    input  logic        i_stall_req,
    output logic        o_fetch_hold,
    output logic        o_mem_redirect,
    output logic        o_mem_wr_en,
    output logic        o_mem_stall,
    output logic [3:0]  o_mem_slice,
    input  logic        i_mem_wr_acp,
    input  logic [15:0] i_mem_word,
    input  logic        i_mem_word_vld
);

    typedef enum logic [2:0] {
        FETCH, BR_ADDR, LS_ADDR, RET_ADDR, SETUP_F, SETUP_LS, ST_DATA
    } state_t;

    state_t      state;
    logic [15:0] addr;
    logic [15:0] ls_pc;
    logic [15:0] wdata;
    logic [15:0] pend_addr;
    logic        pend_vld;
    logic        ls_wr;
    logic        st_phase;

    logic bnd;
    logic grant_ls;
    logic grant_br;
    logic [15:0] ret_addr;

    assign bnd      = (i_sqi_ctr == 2'd3);
    assign grant_ls = i_ls_vld && (!i_br_vld || LS_PRIO);
    assign grant_br = i_br_vld && (!i_ls_vld || !LS_PRIO);
    assign ret_addr = pend_vld ? pend_addr : ls_pc;

    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            state      <= FETCH;
            addr       <= '0;
            ls_pc      <= '0;
            wdata      <= '0;
            pend_addr  <= '0;
            pend_vld   <= 1'b0;
            ls_wr      <= 1'b0;
            st_phase   <= 1'b0;
            o_br_acp   <= 1'b0;
            o_ls_acp   <= 1'b0;
            o_ls_done  <= 1'b0;
            o_ls_rdata <= '0;
        end else begin
            o_br_acp  <= 1'b0;
            o_ls_acp  <= 1'b0;
            o_ls_done <= 1'b0;
            if (bnd) begin
                case (state)
                    FETCH: begin
                        if (grant_ls) begin
                            state    <= LS_ADDR;
                            o_ls_acp <= 1'b1;
                            addr     <= i_ls_addr;
                            ls_pc    <= i_ls_pc;
                            wdata    <= i_ls_wdata;
                            ls_wr    <= i_ls_wr;
                            // a losing branch is parked and becomes the return target
                            if (i_br_vld) begin
                                pend_vld  <= 1'b1;
                                pend_addr <= i_br_addr;
                                o_br_acp  <= 1'b1;
                            end
                        end else if (grant_br) begin
                            state    <= BR_ADDR;
                            o_br_acp <= 1'b1;
                            addr     <= i_br_addr;
                        end
                    end
                    BR_ADDR:  state <= SETUP_F;
                    LS_ADDR:  state <= SETUP_LS;
                    RET_ADDR: state <= SETUP_F;
                    SETUP_F: begin
                        if (i_mem_word_vld) state <= FETCH;
                    end
                    SETUP_LS: begin
                        if (ls_wr) begin
                            if (i_mem_wr_acp) begin
                                state    <= ST_DATA;
                                st_phase <= 1'b0;
                            end
                        end else if (i_mem_word_vld) begin
                            o_ls_rdata <= i_mem_word;
                            o_ls_done  <= 1'b1;
                            state      <= RET_ADDR;
                            addr       <= ret_addr;
                            pend_vld   <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        if (!st_phase) begin
                            st_phase <= 1'b1;
                        end else begin
                            o_ls_done <= 1'b1;
                            state     <= RET_ADDR;
                            addr      <= ret_addr;
                            pend_vld  <= 1'b0;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

    logic [15:0] addr_sh;
    logic [15:0] wdata_sh;

    assign addr_sh  = addr >> {i_sqi_ctr, 2'b00};
    assign wdata_sh = wdata >> {i_sqi_ctr, 2'b00};

    always_comb begin
        o_mem_redirect = (state == BR_ADDR) || (state == LS_ADDR) || (state == RET_ADDR);
        o_mem_wr_en    = ((state == SETUP_LS) && ls_wr) || (state == ST_DATA);
        o_mem_stall    = (state == FETCH) && i_stall_req && i_sqi_rst_n;
        // the word that ends SETUP_F is the first valid instruction, so it is not held
        o_fetch_hold   = (state != FETCH) && !((state == SETUP_F) && bnd && i_mem_word_vld);
        o_mem_slice    = 4'd0;
        if (o_mem_redirect)
            o_mem_slice = addr_sh[3:0];
        else if ((state == ST_DATA) && !st_phase)
            o_mem_slice = wdata_sh[3:0];
    end

endmodule

// File: tb/tb_idli_mem_arb_m.sv
// Directed bench for idli_mem_arb_m: transaction table on an LS_PRIO=1 instance,
// plus hand sequences for branch priority (LS_PRIO=0 instance) and async reset.
module tb_idli_mem_arb_m;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ctr;
    logic        br_vld, ls_vld, ls_wr, stall_req, wr_acp, word_vld;
    logic [15:0] br_addr, ls_addr, ls_wdata, ls_pc, word;

    logic        br_acp, ls_acp, ls_done, fetch_hold, mem_redirect, mem_wr_en, mem_stall;
    logic [15:0] ls_rdata;
    logic [3:0]  mem_slice;
    logic        z_br_acp, z_ls_acp, z_ls_done, z_fetch_hold, z_mem_redirect, z_mem_wr_en, z_mem_stall;
    logic [15:0] z_ls_rdata;
    logic [3:0]  z_mem_slice;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    idli_mem_arb_m #(.LS_PRIO(1'b1)) dut (
        .i_sqi_gck(clk), .i_sqi_rst_n(rst_n), .i_sqi_ctr(ctr),
        .i_br_vld(br_vld), .i_br_addr(br_addr), .o_br_acp(br_acp),
        .i_ls_vld(ls_vld), .i_ls_wr(ls_wr), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
        .i_ls_pc(ls_pc), .o_ls_acp(ls_acp), .o_ls_done(ls_done), .o_ls_rdata(ls_rdata),
        .i_stall_req(stall_req), .o_fetch_hold(fetch_hold), .o_mem_redirect(mem_redirect),
        .o_mem_wr_en(mem_wr_en), .o_mem_stall(mem_stall), .o_mem_slice(mem_slice),
        .i_mem_wr_acp(wr_acp), .i_mem_word(word), .i_mem_word_vld(word_vld)
    );

    idli_mem_arb_m #(.LS_PRIO(1'b0)) dut0 (
        .i_sqi_gck(clk), .i_sqi_rst_n(rst_n), .i_sqi_ctr(ctr),
        .i_br_vld(br_vld), .i_br_addr(br_addr), .o_br_acp(z_br_acp),
        .i_ls_vld(ls_vld), .i_ls_wr(ls_wr), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
        .i_ls_pc(ls_pc), .o_ls_acp(z_ls_acp), .o_ls_done(z_ls_done), .o_ls_rdata(z_ls_rdata),
        .i_stall_req(stall_req), .o_fetch_hold(z_fetch_hold), .o_mem_redirect(z_mem_redirect),
        .o_mem_wr_en(z_mem_wr_en), .o_mem_stall(z_mem_stall), .o_mem_slice(z_mem_slice),
        .i_mem_wr_acp(wr_acp), .i_mem_word(word), .i_mem_word_vld(word_vld)
    );

    typedef struct {
        bit          br;
        bit          ls;
        bit          wr;
        logic [15:0] br_addr;
        logic [15:0] ls_addr;
        logic [15:0] wdata;
        logic [15:0] pc;
        logic [15:0] mem_word;
        logic [15:0] exp_addr;
        logic [15:0] exp_ret;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t ctr=%0d)", nm, got, exp, $time, ctr);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1 ctr = ctr + 2'd1;
        #1;
    endtask

    task automatic to_boundary();
        while (ctr != 2'd3) tick();
    endtask

    task automatic addr_period(input string nm, input logic [15:0] a);
        for (int i = 0; i < 4; i++) begin
            chk({nm, " redirect"}, {15'd0, mem_redirect}, 16'd1);
            chk({nm, " hold"}, {15'd0, fetch_hold}, 16'd1);
            chk({nm, " slice"}, {12'd0, mem_slice}, {12'd0, 4'(a >> (4 * i))});
            tick();
        end
    endtask

    task automatic fetch_return(input string nm);
        for (int i = 0; i < 7; i++) begin
            chk({nm, " setup hold"}, {15'd0, fetch_hold}, 16'd1);
            chk({nm, " setup redirect"}, {15'd0, mem_redirect}, 16'd0);
            chk({nm, " setup wr_en"}, {15'd0, mem_wr_en}, 16'd0);
            tick();
        end
        word_vld = 1'b1;
        word     = 16'h00AA;
        #1;
        chk({nm, " first word hold"}, {15'd0, fetch_hold}, 16'd0);
        tick();
        word_vld = 1'b0;
        word     = 16'h0000;
        #1;
        chk({nm, " fetch hold"}, {15'd0, fetch_hold}, 16'd0);
        chk({nm, " fetch redirect"}, {15'd0, mem_redirect}, 16'd0);
        stall_req = 1'b1;
        #1;
        chk({nm, " stall pass"}, {15'd0, mem_stall}, 16'd1);
        stall_req = 1'b0;
        #1;
    endtask

    task automatic run_vec(input int k, input vec_t v);
        string nm;
        nm = $sformatf("v%0d", k);
        to_boundary();
        br_vld   = v.br;
        br_addr  = v.br_addr;
        ls_vld   = v.ls;
        ls_wr    = v.wr;
        ls_addr  = v.ls_addr;
        ls_wdata = v.wdata;
        ls_pc    = v.pc;
        #1;
        tick();
        chk({nm, " br_acp"}, {15'd0, br_acp}, {15'd0, v.br});
        chk({nm, " ls_acp"}, {15'd0, ls_acp}, {15'd0, v.ls});
        // later changes on the request buses must not leak into the access
        br_vld   = 1'b0;
        ls_vld   = 1'b0;
        br_addr  = ~v.br_addr;
        ls_addr  = ~v.ls_addr;
        ls_wdata = ~v.wdata;
        ls_pc    = ~v.pc;
        #1;
        addr_period({nm, " addr"}, v.exp_addr);
        if (!v.ls) begin
            fetch_return(nm);
        end else if (!v.wr) begin
            for (int i = 0; i < 4; i++) begin
                chk({nm, " ld wr_en"}, {15'd0, mem_wr_en}, 16'd0);
                chk({nm, " ld early done"}, {15'd0, ls_done}, 16'd0);
                tick();
            end
            tick(); tick(); tick();
            word_vld = 1'b1;
            word     = v.mem_word;
            #1;
            tick();
            word_vld = 1'b0;
            word     = 16'h0000;
            chk({nm, " ld done"}, {15'd0, ls_done}, 16'd1);
            chk({nm, " ld rdata"}, ls_rdata, v.mem_word);
            addr_period({nm, " ret"}, v.exp_ret);
            fetch_return(nm);
        end else begin
            for (int i = 0; i < 4; i++) begin
                chk({nm, " st setup wr_en"}, {15'd0, mem_wr_en}, 16'd1);
                tick();
            end
            wr_acp = 1'b1;
            for (int i = 0; i < 4; i++) tick();
            wr_acp = 1'b0;
            for (int i = 0; i < 4; i++) begin
                chk({nm, " st data wr_en"}, {15'd0, mem_wr_en}, 16'd1);
                chk({nm, " st data slice"}, {12'd0, mem_slice}, {12'd0, 4'(v.wdata >> (4 * i))});
                tick();
            end
            for (int i = 0; i < 4; i++) begin
                chk({nm, " st pad wr_en"}, {15'd0, mem_wr_en}, 16'd1);
                chk({nm, " st pad slice"}, {12'd0, mem_slice}, 16'd0);
                chk({nm, " st early done"}, {15'd0, ls_done}, 16'd0);
                tick();
            end
            chk({nm, " st done"}, {15'd0, ls_done}, 16'd1);
            addr_period({nm, " ret"}, v.exp_ret);
            fetch_return(nm);
        end
    endtask

    initial begin
        //          br    ls    wr    br_addr   ls_addr   wdata     pc        mem_word  exp_addr  exp_ret
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'hA35C, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hA35C, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0040, 16'h0000, 16'h0102, 16'hBEEF, 16'h0040, 16'h0102};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0080, 16'h1234, 16'h0300, 16'h0000, 16'h0080, 16'h0300};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0200, 16'h0050, 16'h0000, 16'h0777, 16'h1357, 16'h0050, 16'h0200};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 16'hCAFE, 16'h0F0F, 16'h5A5A, 16'h1111, 16'h0000, 16'h0F0F, 16'hCAFE};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFE, 16'h8001, 16'hFFFF, 16'hFFFE};

        rst_n = 1'b0; ctr = 2'd0;
        br_vld = 1'b0; ls_vld = 1'b0; ls_wr = 1'b0; wr_acp = 1'b0; word_vld = 1'b0;
        br_addr = '0; ls_addr = '0; ls_wdata = '0; ls_pc = '0; word = '0;
        stall_req = 1'b1;
        tick(); tick();
        chk("rst hold", {15'd0, fetch_hold}, 16'd0);
        chk("rst redirect", {15'd0, mem_redirect}, 16'd0);
        chk("rst stall", {15'd0, mem_stall}, 16'd0);
        chk("rst slice", {12'd0, mem_slice}, 16'd0);
        chk("rst rdata", ls_rdata, 16'd0);
        chk("rst acps", {14'd0, br_acp, ls_acp}, 16'd0);
        stall_req = 1'b0;
        rst_n = 1'b1;
        tick(); tick(); tick();
        word_vld = 1'b1; word = 16'h1111;
        #1;
        chk("post-rst hold", {15'd0, fetch_hold}, 16'd0);
        chk("post-rst redirect", {15'd0, mem_redirect}, 16'd0);
        tick();
        word_vld = 1'b0;
        #1;
        chk("post-rst stays fetch", {15'd0, fetch_hold}, 16'd0);

        for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);

        // LS_PRIO=0: branch wins, held load is taken at a later FETCH boundary
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        to_boundary();
        br_vld = 1'b1; br_addr = 16'h0200;
        ls_vld = 1'b1; ls_wr = 1'b0; ls_addr = 16'h0040; ls_pc = 16'h0102;
        #1;
        tick();
        chk("p0 br_acp", {15'd0, z_br_acp}, 16'd1);
        chk("p0 ls_acp", {15'd0, z_ls_acp}, 16'd0);
        chk("p1 both acp", {14'd0, br_acp, ls_acp}, 16'd3);
        br_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("p0 br redirect", {15'd0, z_mem_redirect}, 16'd1);
            chk("p0 br slice", {12'd0, z_mem_slice}, {12'd0, 4'(16'h0200 >> (4 * i))});
            tick();
        end
        chk("p0 ls_acp busy", {15'd0, z_ls_acp}, 16'd0);
        tick(); tick(); tick();
        word_vld = 1'b1;
        #1;
        tick();
        word_vld = 1'b0;
        chk("p0 ls_acp setup", {15'd0, z_ls_acp}, 16'd0);
        chk("p0 back in fetch", {15'd0, z_fetch_hold}, 16'd0);
        to_boundary();
        tick();
        chk("p0 late ls_acp", {15'd0, z_ls_acp}, 16'd1);
        ls_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("p0 ls slice", {12'd0, z_mem_slice}, {12'd0, 4'(16'h0040 >> (4 * i))});
            tick();
        end

        // async reset in the middle of a store data period
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        to_boundary();
        ls_vld = 1'b1; ls_wr = 1'b1; ls_addr = 16'h0080; ls_wdata = 16'h1234; ls_pc = 16'h0000;
        #1;
        tick();
        ls_vld = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        wr_acp = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        wr_acp = 1'b0;
        tick();
        chk("pre-rst st slice", {12'd0, mem_slice}, 16'h0003);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid-rst wr_en", {15'd0, mem_wr_en}, 16'd0);
        chk("mid-rst slice", {12'd0, mem_slice}, 16'd0);
        chk("mid-rst hold", {15'd0, fetch_hold}, 16'd0);
        chk("mid-rst redirect", {15'd0, mem_redirect}, 16'd0);
        for (int i = 0; i < 8; i++) begin
            chk("mid-rst no done", {15'd0, ls_done}, 16'd0);
            tick();
        end
        rst_n = 1'b1;
        tick();
        chk("after-rst no done", {15'd0, ls_done}, 16'd0);
        stall_req = 1'b1;
        #1;
        chk("after-rst fetch stall", {15'd0, mem_stall}, 16'd1);
        chk("after-rst hold", {15'd0, fetch_hold}, 16'd0);
        stall_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
